// File: rtl/channel_pkt_arbiter_pkg.sv
// Shared types for the packet-atomic channel arbiter.
// metadata_t mirrors the layout of the shared metadata struct used by the channel FIFOs.
package chan_arb_pkg;
  localparam int CH_W    = 2;
  localparam int PKT_W   = 512;
  localparam int EMPTY_W = 6;

  typedef struct packed {
    logic [15:0] len;
    logic [15:0] flow;
    logic [31:0] tag;
  } metadata_t;

  typedef enum logic [1:0] {IDLE, META, PKT} arb_state_t;
endpackage

// File: rtl/channel_pkt_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after ptr wins.
module rr_pick
  import chan_arb_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic              any
);
  logic [2*NUM_CH-1:0] req_dbl;
  logic [2*NUM_CH-1:0] gnt_dbl;
  logic [NUM_CH-1:0]   rot_req;
  logic [NUM_CH-1:0]   rot_gnt;

  // Rotate so channel ptr+1 lands on bit 0, keep the lowest set bit, rotate back.
  always_comb begin
    req_dbl = {req, req};
    rot_req = req_dbl[int'(ptr) + 1 +: NUM_CH];
    rot_gnt = rot_req & (~rot_req + NUM_CH'(1));
    gnt_dbl = {rot_gnt, rot_gnt} << (int'(ptr) + 1);
    gnt     = gnt_dbl[2*NUM_CH-1:NUM_CH];
    any     = |req;
  end
endmodule

// File: rtl/channel_pkt_arbiter.sv
// Packet-atomic round-robin merge of NUM_CH meta/pkt channel streams into one tagged stream.
module channel_pkt_arbiter
  import chan_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   in_meta_valid,
  input  metadata_t           in_meta_data [NUM_CH],
  output logic [NUM_CH-1:0]   in_meta_ready,
  input  logic [PKT_W-1:0]    in_pkt_data [NUM_CH],
  input  logic [NUM_CH-1:0]   in_pkt_valid,
  input  logic [NUM_CH-1:0]   in_pkt_sop,
  input  logic [NUM_CH-1:0]   in_pkt_eop,
  input  logic [EMPTY_W-1:0]  in_pkt_empty [NUM_CH],
  output logic [NUM_CH-1:0]   in_pkt_ready,
  output metadata_t           out_meta_data,
  output logic                out_meta_valid,
  input  logic                out_meta_ready,
  input  logic                out_meta_almost_full,
  output logic [CH_W-1:0]     out_meta_channel,
  output logic [PKT_W-1:0]    out_pkt_data,
  output logic                out_pkt_sop,
  output logic                out_pkt_eop,
  output logic [EMPTY_W-1:0]  out_pkt_empty,
  output logic                out_pkt_valid,
  input  logic                out_pkt_ready,
  input  logic                out_pkt_almost_full,
  output logic [CH_W-1:0]     out_pkt_channel,
  output logic [CNT_W-1:0]    pkt_cnt [NUM_CH],
  output logic                sop_err
);
  arb_state_t        state_q, state_d;
  logic [CH_W-1:0]   gnt_q, gnt_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic              first_q, first_d;
  logic              sop_err_q, sop_err_d;
  logic [CNT_W-1:0]  pkt_cnt_q [NUM_CH];
  logic [CNT_W-1:0]  pkt_cnt_d [NUM_CH];

  logic [NUM_CH-1:0] pick_oh;
  logic              pick_any;
  logic [CH_W-1:0]   pick_idx;
  logic              grant_new;
  logic              beat_acc;

  rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
    .req (in_meta_valid & in_pkt_valid),
    .ptr (ptr_q),
    .gnt (pick_oh),
    .any (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pick_oh[i]) pick_idx = CH_W'(i);
    end
  end

  // Backpressure hints only hold off new grants; a packet in flight always finishes.
  assign grant_new = (state_q == IDLE) && pick_any && !out_meta_almost_full && !out_pkt_almost_full;
  assign beat_acc  = (state_q == PKT) && in_pkt_valid[gnt_q] && out_pkt_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_new) state_d = META;
      META:    if (out_meta_ready) state_d = PKT;
      PKT:     if (beat_acc && in_pkt_eop[gnt_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    first_d   = first_q;
    sop_err_d = sop_err_q;
    for (int i = 0; i < NUM_CH; i++) pkt_cnt_d[i] = pkt_cnt_q[i];
    if (grant_new) begin
      gnt_d = pick_idx;
      ptr_d = pick_idx;
    end
    if (state_q == META) first_d = 1'b1;
    if (beat_acc) begin
      first_d = 1'b0;
      if (first_q && !in_pkt_sop[gnt_q]) sop_err_d = 1'b1;
      if (in_pkt_eop[gnt_q]) pkt_cnt_d[gnt_q] = pkt_cnt_q[gnt_q] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q     <= '0;
      ptr_q     <= CH_W'(NUM_CH - 1);
      first_q   <= 1'b0;
      sop_err_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) pkt_cnt_q[i] <= '0;
    end else begin
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      first_q   <= first_d;
      sop_err_q <= sop_err_d;
      for (int i = 0; i < NUM_CH; i++) pkt_cnt_q[i] <= pkt_cnt_d[i];
    end
  end

  always_comb begin
    in_meta_ready    = '0;
    in_pkt_ready     = '0;
    out_meta_valid   = 1'b0;
    out_pkt_valid    = 1'b0;
    out_meta_data    = in_meta_data[gnt_q];
    out_meta_channel = gnt_q;
    out_pkt_data     = in_pkt_data[gnt_q];
    out_pkt_sop      = in_pkt_sop[gnt_q];
    out_pkt_eop      = in_pkt_eop[gnt_q];
    out_pkt_empty    = in_pkt_empty[gnt_q];
    out_pkt_channel  = gnt_q;
    if (state_q == META) begin
      out_meta_valid       = 1'b1;
      in_meta_ready[gnt_q] = out_meta_ready;
    end
    if (state_q == PKT) begin
      out_pkt_valid       = in_pkt_valid[gnt_q];
      in_pkt_ready[gnt_q] = out_pkt_ready;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
  assign sop_err = sop_err_q;
endmodule

// File: tb/tb_channel_pkt_arbiter.sv
// Randomized bench for channel_pkt_arbiter with a transaction-level reference model and directed scenarios.
module tb_channel_pkt_arbiter;
  import chan_arb_pkg::*;
  localparam int N  = 4;
  localparam int CW = 32;

  typedef struct {
    logic [PKT_W-1:0]   data;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]       in_meta_valid, in_meta_ready;
  metadata_t          in_meta_data [N];
  logic [PKT_W-1:0]   in_pkt_data [N];
  logic [N-1:0]       in_pkt_valid, in_pkt_sop, in_pkt_eop, in_pkt_ready;
  logic [EMPTY_W-1:0] in_pkt_empty [N];
  metadata_t          out_meta_data;
  logic               out_meta_valid, out_meta_ready, out_meta_almost_full;
  logic [CH_W-1:0]    out_meta_channel, out_pkt_channel;
  logic [PKT_W-1:0]   out_pkt_data;
  logic               out_pkt_sop, out_pkt_eop, out_pkt_valid, out_pkt_ready, out_pkt_almost_full;
  logic [EMPTY_W-1:0] out_pkt_empty;
  logic [CW-1:0]      pkt_cnt [N];
  logic               sop_err;

  channel_pkt_arbiter #(.NUM_CH(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_meta_valid(in_meta_valid), .in_meta_data(in_meta_data), .in_meta_ready(in_meta_ready),
    .in_pkt_data(in_pkt_data), .in_pkt_valid(in_pkt_valid), .in_pkt_sop(in_pkt_sop),
    .in_pkt_eop(in_pkt_eop), .in_pkt_empty(in_pkt_empty), .in_pkt_ready(in_pkt_ready),
    .out_meta_data(out_meta_data), .out_meta_valid(out_meta_valid), .out_meta_ready(out_meta_ready),
    .out_meta_almost_full(out_meta_almost_full), .out_meta_channel(out_meta_channel),
    .out_pkt_data(out_pkt_data), .out_pkt_sop(out_pkt_sop), .out_pkt_eop(out_pkt_eop),
    .out_pkt_empty(out_pkt_empty), .out_pkt_valid(out_pkt_valid), .out_pkt_ready(out_pkt_ready),
    .out_pkt_almost_full(out_pkt_almost_full), .out_pkt_channel(out_pkt_channel),
    .pkt_cnt(pkt_cnt), .sop_err(sop_err)
  );

  always #5 clk = ~clk;

  // Upstream channel FIFOs, modelled as queues.
  metadata_t meta_q [N][$];
  beat_t     beat_q [N][$];
  int        added [N];
  int        beats_out [N];
  int        gnt_log [$];
  bit        meta_pop [N];
  bit        pkt_pop [N];
  bit        flush;

  int total = 0;
  int bad   = 0;
  int seq   = 0;
  int pkt_gap = 0, rdy_pct = 100, maf_pct = 0, paf_pct = 0;
  bit toggle_rdy = 0;

  // Reference model: who owns the output, whether its meta word has gone, RR history.
  int            m_phase;   // 0 = no owner, 1 = owner must send meta, 2 = owner sending beats
  int            m_own;
  int            m_last;
  bit            m_first;
  bit            m_err;
  logic [CW-1:0] m_cnt [N];

  task automatic chk(string name, logic [PKT_W-1:0] act, logic [PKT_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_own = 0; m_last = N - 1; m_first = 0; m_err = 0;
    for (int c = 0; c < N; c++) m_cnt[c] = '0;
  endtask

  task automatic add_pkt(int ch, int nbeats, bit bad_sop);
    beat_t b;
    seq++;
    meta_q[ch].push_back(metadata_t'({16'(nbeats), 16'(ch), 32'(seq)}));
    for (int k = 0; k < nbeats; k++) begin
      for (int w = 0; w < PKT_W / 32; w++) b.data[w*32 +: 32] = $urandom;
      b.sop   = (k == 0) && !bad_sop;
      b.eop   = (k == nbeats - 1);
      b.empty = b.eop ? EMPTY_W'($urandom_range(63)) : '0;
      beat_q[ch].push_back(b);
    end
    added[ch]++;
  endtask

  // Compare DUT against model at the falling edge, then advance the model across the next rising edge.
  task automatic check_cycle();
    logic [N-1:0] e_mr, e_pr;
    int best, bestd, d;
    e_mr = '0; e_pr = '0;
    if (m_phase == 1 && out_meta_ready) e_mr[m_own] = 1'b1;
    if (m_phase == 2 && out_pkt_ready)  e_pr[m_own] = 1'b1;
    chk("meta_valid", out_meta_valid, m_phase == 1);
    chk("pkt_valid", out_pkt_valid, m_phase == 2 && in_pkt_valid[m_own]);
    chk("in_meta_ready", in_meta_ready, e_mr);
    chk("in_pkt_ready", in_pkt_ready, e_pr);
    chk("sop_err", sop_err, m_err);
    for (int c = 0; c < N; c++) chk($sformatf("pkt_cnt%0d", c), pkt_cnt[c], m_cnt[c]);
    if (m_phase == 1 && meta_q[m_own].size() > 0) begin
      chk("meta_chan", out_meta_channel, m_own);
      chk("meta_data", out_meta_data, meta_q[m_own][0]);
    end
    if (m_phase == 2 && in_pkt_valid[m_own] && beat_q[m_own].size() > 0) begin
      chk("pkt_chan", out_pkt_channel, m_own);
      chk("pkt_data", out_pkt_data, beat_q[m_own][0].data);
      chk("pkt_sop", out_pkt_sop, beat_q[m_own][0].sop);
      chk("pkt_eop", out_pkt_eop, beat_q[m_own][0].eop);
      chk("pkt_empty", out_pkt_empty, beat_q[m_own][0].empty);
    end
    for (int c = 0; c < N; c++) begin
      meta_pop[c] = in_meta_valid[c] && in_meta_ready[c];
      pkt_pop[c]  = in_pkt_valid[c] && in_pkt_ready[c];
      if (pkt_pop[c]) beats_out[c]++;
    end
    if (out_meta_valid && out_meta_ready) gnt_log.push_back(int'(out_meta_channel));

    if (rst) begin
      model_reset();
    end else if (m_phase == 0) begin
      best = -1; bestd = N;
      for (int c = 0; c < N; c++) begin
        d = (c - m_last - 1 + 2 * N) % N;
        if (in_meta_valid[c] && in_pkt_valid[c] && d < bestd) begin best = c; bestd = d; end
      end
      if (best >= 0 && !out_meta_almost_full && !out_pkt_almost_full) begin
        m_own = best; m_last = best; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (out_meta_ready) begin m_phase = 2; m_first = 1; end
    end else if (in_pkt_valid[m_own] && out_pkt_ready) begin
      if (m_first && !in_pkt_sop[m_own]) m_err = 1;
      m_first = 0;
      if (in_pkt_eop[m_own]) begin m_cnt[m_own] = m_cnt[m_own] + 1; m_phase = 0; end
    end
  endtask

  task automatic drive();
    for (int c = 0; c < N; c++) begin
      if (meta_pop[c] && meta_q[c].size() > 0) void'(meta_q[c].pop_front());
      if (pkt_pop[c] && beat_q[c].size() > 0)  void'(beat_q[c].pop_front());
      meta_pop[c] = 0; pkt_pop[c] = 0;
    end
    if (flush) begin
      for (int c = 0; c < N; c++) begin
        meta_q[c].delete(); beat_q[c].delete(); added[c] = 0; beats_out[c] = 0;
      end
      gnt_log.delete();
      flush = 0;
    end
    for (int c = 0; c < N; c++) begin
      in_meta_valid[c] = meta_q[c].size() > 0;
      in_meta_data[c]  = (meta_q[c].size() > 0) ? meta_q[c][0] : '0;
      in_pkt_valid[c]  = beat_q[c].size() > 0 && ($urandom_range(99) >= pkt_gap);
      if (beat_q[c].size() > 0) begin
        in_pkt_data[c] = beat_q[c][0].data; in_pkt_sop[c] = beat_q[c][0].sop;
        in_pkt_eop[c]  = beat_q[c][0].eop;  in_pkt_empty[c] = beat_q[c][0].empty;
      end else begin
        in_pkt_data[c] = '0; in_pkt_sop[c] = 0; in_pkt_eop[c] = 0; in_pkt_empty[c] = '0;
      end
    end
    out_meta_ready       = $urandom_range(99) < rdy_pct;
    out_pkt_ready        = toggle_rdy ? !out_pkt_ready : ($urandom_range(99) < rdy_pct);
    out_meta_almost_full = $urandom_range(99) < maf_pct;
    out_pkt_almost_full  = $urandom_range(99) < paf_pct;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic do_reset();
    rst = 1; flush = 1;
    step();
    rst = 0;
  endtask

  task automatic lit_reset_checks(string tag);
    chk({tag, "_meta_valid"}, out_meta_valid, 0);
    chk({tag, "_pkt_valid"}, out_pkt_valid, 0);
    chk({tag, "_in_meta_ready"}, in_meta_ready, 0);
    chk({tag, "_in_pkt_ready"}, in_pkt_ready, 0);
    chk({tag, "_meta_chan"}, out_meta_channel, 0);
    chk({tag, "_sop_err"}, sop_err, 0);
    for (int c = 0; c < N; c++) chk($sformatf("%s_cnt%0d", tag, c), pkt_cnt[c], 0);
  endtask

  initial begin
    int exp_order [5];
    bit drained;
    exp_order = '{0, 1, 2, 3, 0};
    model_reset();
    flush = 1; rst = 1; out_pkt_ready = 1;
    drive();
    do_reset();
    lit_reset_checks("rst");

    // 1: single 3-beat packet on ch0
    add_pkt(0, 3, 0);
    for (int i = 0; i < 40 && beats_out[0] < 3; i++) step();
    chk("t1_beats", beats_out[0], 3);
    chk("t1_cnt0", pkt_cnt[0], 1);
    chk("t1_gnt_ch", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);

    // 2: all channels eligible, single-beat packets
    do_reset();
    for (int c = 0; c < N; c++) add_pkt(c, 1, 0);
    add_pkt(0, 1, 0);
    for (int i = 0; i < 80 && gnt_log.size() < 5; i++) step();
    for (int k = 0; k < 5; k++)
      chk($sformatf("t2_order%0d", k), (gnt_log.size() > k) ? gnt_log[k] : -1, exp_order[k]);

    // 3: pkt almost_full raised while ch1 is mid-packet
    do_reset();
    add_pkt(1, 3, 0);
    for (int i = 0; i < 40 && gnt_log.size() < 1; i++) step();
    add_pkt(0, 1, 0);
    paf_pct = 100;
    for (int i = 0; i < 20; i++) step();
    chk("t3_cnt1", pkt_cnt[1], 1);
    chk("t3_no_grant", gnt_log.size(), 1);
    paf_pct = 0;
    for (int i = 0; i < 40 && gnt_log.size() < 2; i++) step();
    chk("t3_next_gnt", (gnt_log.size() > 1) ? gnt_log[1] : -1, 0);

    // 4: out_pkt_ready toggling on a 4-beat packet
    do_reset();
    toggle_rdy = 1;
    add_pkt(3, 4, 0);
    for (int i = 0; i < 60 && beats_out[3] < 4; i++) step();
    toggle_rdy = 0;
    chk("t4_beats", beats_out[3], 4);
    chk("t4_cnt3", pkt_cnt[3], 1);

    // 5: missing SOP on ch2 sets a sticky error
    do_reset();
    add_pkt(2, 2, 1);
    for (int i = 0; i < 40 && beats_out[2] < 2; i++) step();
    chk("t5_err_set", sop_err, 1);
    add_pkt(2, 1, 0);
    for (int i = 0; i < 40 && beats_out[2] < 3; i++) step();
    chk("t5_err_sticky", sop_err, 1);
    chk("t5_cnt2", pkt_cnt[2], 2);
    do_reset();
    chk("t5_err_clr", sop_err, 0);

    // 6: reset while ch1's second beat is on the bus
    add_pkt(1, 4, 0);
    for (int i = 0; i < 40 && beats_out[1] < 1; i++) step();
    chk("t6_first_beat", beats_out[1], 1);
    chk("t6_pkt_valid_pre", out_pkt_valid, 1);
    do_reset();
    lit_reset_checks("t6");
    for (int c = N - 1; c >= 0; c--) add_pkt(c, 1, 0);
    for (int i = 0; i < 40 && gnt_log.size() < 1; i++) step();
    chk("t6_restart_ch0", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);

    // Random traffic with gaps, backpressure and occasional bad SOP
    do_reset();
    pkt_gap = 20; rdy_pct = 70; maf_pct = 10; paf_pct = 10;
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < N; c++)
        if (meta_q[c].size() < 3 && $urandom_range(9) == 0)
          add_pkt(c, $urandom_range(1, 5), $urandom_range(19) == 0);
      step();
    end
    pkt_gap = 0; rdy_pct = 100; maf_pct = 0; paf_pct = 0;
    drained = 0;
    for (int i = 0; i < 2000 && !drained; i++) begin
      step();
      drained = (m_phase == 0);
      for (int c = 0; c < N; c++) if (meta_q[c].size() > 0 || beat_q[c].size() > 0) drained = 0;
    end
    chk("drain", drained, 1);
    for (int c = 0; c < N; c++) chk($sformatf("rand_cnt%0d", c), pkt_cnt[c], added[c]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
